// File: rtl/serial_pkg.sv
// Shared types and frame-size helpers for the serial transmit and receive blocks.
package serial_pkg;

  typedef enum logic {IDLE, SEND} tx_state_t;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  // Start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int parity_en);
    return data_bits + 2 + parity_en;
  endfunction

endpackage

// File: rtl/tx_bsc.sv
// Bit-sample counter: paces each serial bit to OVERSAMPLE clock cycles.
module tx_bsc
  import serial_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bit_done
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] sample_cnt;

  // Held at zero outside a frame so every bit starts on a clean count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_cnt <= '0;
    end else if (!enable) begin
      sample_cnt <= '0;
    end else if (sample_cnt == LAST) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

  assign bit_done = enable && (sample_cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Serial character transmitter: start, LSB-first data, optional even parity, stop.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int PARITY_EN  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 char_sent
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_EN);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  tx_state_t             state, state_next;
  logic [FRAME_BITS-1:0] frame, frame_next;
  logic [3:0]            bit_cnt, bit_cnt_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;
  logic                  sent_reg, sent_next;
  logic                  bit_done;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] d);
    logic [FRAME_BITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[DATA_BITS:1] = d;
    if (PARITY_EN != 0) f[DATA_BITS+1] = ^d;
    return f;
  endfunction

  tx_bsc #(.OVERSAMPLE(OVERSAMPLE)) u_bsc (
    .clk      (clk),
    .reset    (reset),
    .enable   (state == SEND),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      frame    <= '0;
      bit_cnt  <= '0;
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
      sent_reg <= 1'b0;
    end else begin
      state    <= state_next;
      frame    <= frame_next;
      bit_cnt  <= bit_cnt_next;
      tx_reg   <= tx_next;
      busy_reg <= busy_next;
      sent_reg <= sent_next;
    end
  end

  // Outputs lag the state by one register stage; a registered busy still high
  // while IDLE marks the cycle the last stop bit finishes.
  always_comb begin
    state_next   = state;
    frame_next   = frame;
    bit_cnt_next = bit_cnt;
    tx_next      = 1'b1;
    busy_next    = 1'b0;
    sent_next    = 1'b0;
    case (state)
      IDLE: begin
        sent_next = busy_reg;
        if (load && !busy_reg) begin
          frame_next   = build_frame(data_in);
          bit_cnt_next = '0;
          state_next   = SEND;
        end
      end
      SEND: begin
        tx_next   = frame[0];
        busy_next = 1'b1;
        if (bit_done) begin
          frame_next = {1'b1, frame[FRAME_BITS-1:1]};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_next = '0;
            state_next   = IDLE;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_out    = tx_reg;
  assign busy      = busy_reg;
  assign char_sent = sent_reg;

endmodule
